// File: rtl/cpu_types_pkg.sv
// Shared fetch-stage types: controller FSM states, redirect kinds and the
// redirect priority pick (branch beats register jump beats immediate jump).
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    BR   = 2'd1,
    JR   = 2'd2,
    J    = 2'd3
  } redirect_t;

  // Lower-priority requests arriving in the same cycle are simply dropped.
  function automatic redirect_t pick_redirect(input logic br, input logic jr, input logic j);
    if (br) return BR;
    if (jr) return JR;
    if (j)  return J;
    return NONE;
  endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter with synchronous active-low clear; sticks at all-ones.
module fetch_perf_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !(&count_q)) count_d = count_q + ONE;
  end

  // NOTE: state updates use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage controller: PC enable/select, IF/ID and ID/EX flushes, halt handling.
// Define FETCH_PERF_EN to build the saturating fetch/stall performance counters.
module fetch_controller
  import cpu_types_pkg::*;
#(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               ihit,
  input  logic               dmem_busy,
  input  logic               stall_req,
  input  logic               br_taken,
  input  logic               jr,
  input  logic               jump,
  input  logic               halt,
  output logic               PCSrc,
  output logic               JR,
  output logic               Jump,
  output logic               PC_EN,
  output logic               imemREN,
  output logic               flush_ifid,
  output logic               flush_idex,
  output logic               hold_ex,
  output logic               halted,
  output logic [COUNT_W-1:0] fetch_count,
  output logic [COUNT_W-1:0] stall_count
);

  fetch_state_t state_q, state_d;
  redirect_t    pend_q, pend_d;
  redirect_t    kind;
  logic         go;

  // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= RUN;
      pend_q  <= NONE;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // NOTE: every output and next-state signal gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    PCSrc      = 1'b0;
    JR         = 1'b0;
    Jump       = 1'b0;
    PC_EN      = 1'b0;
    imemREN    = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    hold_ex    = 1'b0;
    halted     = 1'b0;
    go         = ihit & ~dmem_busy;
    // While pending, the latched redirect owns the PC; fresh requests are ignored.
    kind       = (state_q == PEND) ? pend_q : pick_redirect(br_taken, jr, jump);

    if (nRST) begin
      case (state_q)
        RUN, PEND: begin
          imemREN = 1'b1;
          hold_ex = (state_q == PEND) | ((kind != NONE) & ~go);
          if (halt) begin
            state_d = HALTED;
            pend_d  = NONE;
          end else if (kind != NONE) begin
            if (go) begin
              PC_EN      = 1'b1;
              PCSrc      = (kind == BR);
              JR         = (kind == cpu_types_pkg::JR);
              Jump       = (kind == J);
              flush_ifid = 1'b1;
              flush_idex = (kind == BR);
              state_d    = RUN;
              pend_d     = NONE;
            end else begin
              state_d = PEND;
              pend_d  = kind;
            end
          end else begin
            PC_EN = ihit & ~stall_req & ~dmem_busy;
          end
        end
        HALTED:  halted  = 1'b1;
        default: state_d = RUN;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_counter #(.W(COUNT_W)) u_fetch_cnt (
    .clk     (CLK),
    .rst_n   (nRST),
    .inc_i   (PC_EN),
    .count_o (fetch_count)
  );

  fetch_perf_counter #(.W(COUNT_W)) u_stall_cnt (
    .clk     (CLK),
    .rst_n   (nRST),
    .inc_i   (imemREN & ~PC_EN),
    .count_o (stall_count)
  );
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios then random traffic, all
// checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch_controller;

  localparam int unsigned CW = 6;
  localparam int          CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          nRST, ihit, dmem_busy, stall_req, br_taken, jr, jump, halt;
  logic          PCSrc, JR, Jump, PC_EN, imemREN, flush_ifid, flush_idex, hold_ex, halted;
  logic [CW-1:0] fetch_count, stall_count;

  int checks = 0;
  int errors = 0;

  fetch_controller #(.COUNT_W(CW)) u_dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_busy(dmem_busy), .stall_req(stall_req),
    .br_taken(br_taken), .jr(jr), .jump(jump), .halt(halt),
    .PCSrc(PCSrc), .JR(JR), .Jump(Jump), .PC_EN(PC_EN), .imemREN(imemREN),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .hold_ex(hold_ex), .halted(halted),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  // Model state: stopped after a halt; waiting holds 0=none, 1=branch, 2=reg jump, 3=imm jump.
  bit   m_stopped = 1'b0;
  int   m_waiting = 0;
  int   m_fetch   = 0;
  int   m_stall   = 0;
  bit   cnt_valid = 1'b0;
  int   m_kind;
  bit   m_go;
  logic [8:0] exp_vec;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic predict();
    bit pcsrc = 0, jrs = 0, jmp = 0, pc_en = 0, imem = 0, fifd = 0, fidex = 0, hold = 0, hlt = 0;
    int want;
    m_kind = 0;
    m_go   = ihit && !dmem_busy;
    if (!nRST) begin
      // everything low
    end else if (m_stopped) begin
      hlt = 1;
    end else begin
      want   = br_taken ? 1 : (jr ? 2 : (jump ? 3 : 0));
      m_kind = (m_waiting != 0) ? m_waiting : want;
      imem   = 1;
      hold   = (m_waiting != 0) || (m_kind != 0 && !m_go);
      if (halt) begin
        // halt cycle: no fetch advance, no flush
      end else if (m_kind != 0) begin
        if (m_go) begin
          pc_en = 1;
          pcsrc = (m_kind == 1);
          jrs   = (m_kind == 2);
          jmp   = (m_kind == 3);
          fifd  = 1;
          fidex = (m_kind == 1);
        end
      end else begin
        pc_en = ihit && !stall_req && !dmem_busy;
      end
    end
    exp_vec = {pcsrc, jrs, jmp, pc_en, imem, fifd, fidex, hold, hlt};
  endtask

  task automatic advance();
    if (!nRST) begin
      m_stopped = 0;
      m_waiting = 0;
      m_fetch   = 0;
      m_stall   = 0;
      cnt_valid = 1;
    end else begin
      if (exp_vec[5])      m_fetch++;
      else if (exp_vec[4]) m_stall++;
      if (!m_stopped) begin
        if (halt)              begin m_stopped = 1; m_waiting = 0; end
        else if (m_kind != 0)  m_waiting = m_go ? 0 : m_kind;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [8:0]    obs;
    logic [CW-1:0] exp_f, exp_s;
    bit            sel_ok;
    obs = {PCSrc, JR, Jump, PC_EN, imemREN, flush_ifid, flush_idex, hold_ex, halted};
    checks++;
    assert (obs === exp_vec) else begin
      errors++;
      $error("FAIL %s outputs {PCSrc,JR,Jump,PC_EN,imemREN,fifd,fidex,hold,halted} got %b want %b",
             tag, obs, exp_vec);
    end
    sel_ok = ($countones({PCSrc, JR, Jump}) == 0) ||
             ($countones({PCSrc, JR, Jump}) == 1 && PC_EN === 1'b1);
    checks++;
    assert (sel_ok === 1'b1) else begin
      errors++;
      $error("FAIL %s select_onehot got sel=%b pc_en=%b want at most one select and only with PC_EN",
             tag, {PCSrc, JR, Jump}, PC_EN);
    end
    if (cnt_valid) begin
`ifdef FETCH_PERF_EN
      exp_f = CW'(sat(m_fetch));
      exp_s = CW'(sat(m_stall));
`else
      exp_f = '0;
      exp_s = '0;
`endif
      checks++;
      assert (fetch_count === exp_f) else begin
        errors++;
        $error("FAIL %s fetch_count got %0d want %0d", tag, fetch_count, exp_f);
      end
      checks++;
      assert (stall_count === exp_s) else begin
        errors++;
        $error("FAIL %s stall_count got %0d want %0d", tag, stall_count, exp_s);
      end
    end
  endtask

  // One cycle: drive inputs just after the edge, check mid-cycle, then clock the model.
  task automatic step(input string tag, input bit n, input bit ih, input bit busy, input bit st,
                      input bit br, input bit jrq, input bit jmp, input bit hl);
    nRST = n; ihit = ih; dmem_busy = busy; stall_req = st;
    br_taken = br; jr = jrq; jump = jmp; halt = hl;
    #2;
    predict();
    check(tag);
    @(posedge CLK);
    advance();
    #1;
  endtask

  initial begin
    //    tag          nRST ihit busy stall br jr  j  halt
    step("reset0",      0,   1,   0,   0,   1, 0, 0, 0);
    step("reset1",      0,   0,   1,   1,   0, 1, 1, 1);

    for (int i = 0; i < 10; i++) step("seq_fetch", 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)  step("stall",     1, 1, 0, 1, 0, 0, 0, 0);
    step("dmem_busy",   1,   1,   1,   0,   0, 0, 0, 0);
    step("imiss",       1,   0,   0,   0,   0, 0, 0, 0);

    step("late_br0",    1,   0,   0,   0,   1, 0, 0, 0);
    step("late_br1",    1,   0,   0,   0,   1, 0, 0, 0);
    step("late_br2",    1,   1,   0,   0,   1, 0, 0, 0);
    step("after_br",    1,   1,   0,   0,   0, 0, 0, 0);

    step("collide_bj",  1,   1,   0,   0,   1, 0, 1, 0);
    step("collide_jrj", 1,   1,   0,   1,   0, 1, 1, 0);
    step("jump_only",   1,   1,   0,   1,   0, 0, 1, 0);

    step("busy_jr",     1,   1,   1,   0,   0, 1, 0, 0);
    step("pend_ignore", 1,   1,   1,   1,   1, 0, 1, 0);
    step("pend_fire",   1,   1,   0,   1,   1, 0, 0, 0);

    step("halt_pend0",  1,   0,   0,   0,   1, 0, 0, 0);
    step("halt_pend1",  1,   1,   0,   0,   0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("halted", 1, 1, 0, 0, 1, 1, 1, 0);
    step("halt_rst",    0,   1,   0,   0,   0, 0, 0, 0);
    step("post_rst",    1,   1,   0,   0,   0, 0, 0, 0);

    step("rst_pend0",   1,   0,   0,   0,   0, 0, 1, 0);
    step("rst_pend1",   0,   0,   0,   0,   0, 0, 0, 0);
    step("rst_pend2",   1,   1,   0,   0,   0, 0, 0, 0);

    for (int i = 0; i < 70; i++) step("saturate", 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70; i++) step("sat_stall", 1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(24) != 0), ($urandom_range(3) != 0), ($urandom_range(4) == 0),
           ($urandom_range(4) == 0), ($urandom_range(5) == 0), ($urandom_range(5) == 0),
           ($urandom_range(5) == 0), ($urandom_range(49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
